// File: rtl/error_lockout_counter_if.sv
// error_lockout_counter_if
//   Bundles the comparator-side strobes and the status outputs of the
//   failed-attempt tracker.
//   master : driven by the code comparator / supervisor (j, correct,
//            admin_clear), reads the status outputs.
//   slave  : the tracker itself (error_count, locked, lock_remaining,
//            alarm, pass, reject).
interface error_lockout_counter_if #(
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned LOCK_W = 8
);
  logic              j;
  logic              correct;
  logic              admin_clear;
  logic [CNT_W-1:0]  error_count;
  logic              locked;
  logic [LOCK_W-1:0] lock_remaining;
  logic              alarm;
  logic              pass;
  logic              reject;

  modport master (
    output j, correct, admin_clear,
    input  error_count, locked, lock_remaining, alarm, pass, reject
  );

  modport slave (
    input  j, correct, admin_clear,
    output error_count, locked, lock_remaining, alarm, pass, reject
  );
endinterface

// File: rtl/error_lockout_counter.sv
// error_lockout_counter
//   Tracks consecutive wrong code entries. Reaching MAX_ERRORS forces a
//   timed lockout whose length doubles with every lockout; after
//   ALARM_LOCKOUTS lockout triggers a sticky alarm is raised instead.
//   LOCK_CYCLES = 0 selects legacy behaviour: a plain wrapping error counter.
// Ports:
//   clk   : system clock, all state updates on the falling edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of error_lockout_counter_if
//           in  j, correct, admin_clear
//           out error_count, locked, lock_remaining, alarm, pass, reject
module error_lockout_counter #(
  parameter int unsigned MAX_ERRORS     = 3,
  parameter int unsigned CNT_W          = 2,
  parameter int unsigned LOCK_CYCLES    = 8,
  parameter int unsigned LOCK_W         = 8,
  parameter int unsigned ALARM_LOCKOUTS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  error_lockout_counter_if.slave  bus
);

  localparam bit LEGACY = (LOCK_CYCLES == 0);
  // lockout_num never exceeds ALARM_LOCKOUTS-1: the trigger that would
  // reach ALARM_LOCKOUTS goes to ALARM instead of incrementing.
  localparam int unsigned LN_W = (ALARM_LOCKOUTS > 1) ? $clog2(ALARM_LOCKOUTS) : 1;
  localparam logic [63:0] LOCK_MAX = (64'd1 << LOCK_W) - 64'd1;

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_LOCKED = 2'd1,
    ST_ALARM  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  error_count_q, error_count_d;
  logic [LN_W-1:0]   lockout_num_q, lockout_num_d;
  logic [LOCK_W-1:0] lock_remaining_q, lock_remaining_d;
  logic              pass_q, pass_d;
  logic              reject_q, reject_d;

  // Lockout length for the next trigger: LOCK_CYCLES << lockout_num,
  // clamped to the largest value lock_remaining can hold.
  logic [63:0]       lock_shift;
  logic [LOCK_W-1:0] lock_load;

  always_comb begin
    lock_shift = 64'(LOCK_CYCLES) << lockout_num_q;
    if ((32'(lockout_num_q) >= 32'd32) || (lock_shift > LOCK_MAX)) begin
      lock_load = LOCK_MAX[LOCK_W-1:0];
    end else begin
      lock_load = lock_shift[LOCK_W-1:0];
    end
  end

  always_comb begin
    state_d          = state_q;
    error_count_d    = error_count_q;
    lockout_num_d    = lockout_num_q;
    lock_remaining_d = lock_remaining_q;
    pass_d           = 1'b0;
    reject_d         = 1'b0;

    if (bus.admin_clear) begin
      // Supervisor clear beats everything, including a j on the same edge.
      state_d          = ST_NORMAL;
      error_count_d    = '0;
      lockout_num_d    = '0;
      lock_remaining_d = '0;
    end else begin
      case (state_q)
        ST_NORMAL: begin
          if (bus.j) begin
            if (bus.correct) begin
              error_count_d = '0;
              lockout_num_d = '0;
              pass_d        = 1'b1;
            end else begin
              reject_d = 1'b1;
              if (LEGACY) begin
                // Counts up to MAX_ERRORS, the next wrong entry wraps to 0.
                if (32'(error_count_q) >= MAX_ERRORS) begin
                  error_count_d = '0;
                end else begin
                  error_count_d = error_count_q + 1'b1;
                end
              end else if ((32'(error_count_q) + 32'd1) < MAX_ERRORS) begin
                error_count_d = error_count_q + 1'b1;
              end else if ((32'(lockout_num_q) + 32'd1) >= ALARM_LOCKOUTS) begin
                state_d       = ST_ALARM;
                error_count_d = '0;
              end else begin
                state_d          = ST_LOCKED;
                error_count_d    = '0;
                lockout_num_d    = lockout_num_q + 1'b1;
                lock_remaining_d = lock_load;
              end
            end
          end
        end
        ST_LOCKED: begin
          // <=1 also covers a zero-length load, so LOCKED can never stick.
          if (lock_remaining_q <= LOCK_W'(1)) begin
            lock_remaining_d = '0;
            state_d          = ST_NORMAL;
          end else begin
            lock_remaining_d = lock_remaining_q - 1'b1;
          end
        end
        ST_ALARM: begin
          lock_remaining_d = '0;
        end
        default: begin
          state_d = ST_NORMAL;
        end
      endcase
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_NORMAL;
      error_count_q    <= '0;
      lockout_num_q    <= '0;
      lock_remaining_q <= '0;
      pass_q           <= 1'b0;
      reject_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      error_count_q    <= error_count_d;
      lockout_num_q    <= lockout_num_d;
      lock_remaining_q <= lock_remaining_d;
      pass_q           <= pass_d;
      reject_q         <= reject_d;
    end
  end

  assign bus.error_count    = error_count_q;
  assign bus.locked         = (state_q == ST_LOCKED);
  assign bus.alarm          = (state_q == ST_ALARM);
  assign bus.lock_remaining = lock_remaining_q;
  assign bus.pass           = pass_q;
  assign bus.reject         = reject_q;

endmodule

// File: doc/error_lockout_counter.md
Name: error_lockout_counter

Overview:
Parametrised failed-attempt tracker for the six-digit lock controller. Counts consecutive wrong code entries and forces a timed lockout when the limit is reached. Each successive lockout is longer, and the block latches an alarm after repeated lockouts. It sits between the code comparator (j/correct strobes) and the lock FSM/display, which consume locked, alarm and error_count.

Parameters:
MAX_ERRORS, 3, wrong entries that trigger a lockout (>=1)
CNT_W, 2, width of error_count; must hold MAX_ERRORS
LOCK_CYCLES, 8, base lockout length in clk cycles; 0 = legacy mode (no lockout, no alarm)
LOCK_W, 8, width of lock_remaining
ALARM_LOCKOUTS, 3, lockout triggers that escalate to alarm (>=1)

Ports:
clk  in  1  system clock; all state updates on falling edge
rst_n  in  1  asynchronous active-low reset
j  in  1  judge strobe, one cycle per completed code entry
correct  in  1  comparator result, qualified by j
admin_clear  in  1  supervisor clear
error_count  out  CNT_W  consecutive wrong entries since last clear/success/lockout
locked  out  1  high while in a timed lockout
lock_remaining  out  LOCK_W  cycles left in the lockout
alarm  out  1  sticky alarm
pass  out  1  one-cycle pulse for an accepted correct entry
reject  out  1  one-cycle pulse for a counted wrong entry

Behaviour:
- Reset (rst_n=0, async): state NORMAL; error_count=0, lockout_num=0 (internal, saturating), lock_remaining=0, locked=0, alarm=0, pass=0, reject=0.
- Registered outputs. Outputs change on the falling edge that samples the input. pass and reject default to 0 every cycle.
- admin_clear has highest priority in every state: all registers return to reset values on that edge, and any j on the same edge is ignored.
- States: NORMAL, LOCKED, ALARM. locked=1 only in LOCKED, alarm=1 only in ALARM.
- NORMAL, j=1, correct=1: error_count<=0, lockout_num<=0, pass<=1.
- NORMAL, j=1, correct=0: reject<=1.
  - If error_count+1 < MAX_ERRORS: error_count<=error_count+1.
  - Else, if lockout_num+1 >= ALARM_LOCKOUTS: go to ALARM, error_count<=0.
  - Else: go to LOCKED, error_count<=0, lockout_num<=lockout_num+1, lock_remaining<=LOCK_CYCLES<<lockout_num (old value), saturated to 2^LOCK_W-1 on overflow.
- LOCKED: j and correct are ignored (no pulses, no counting). lock_remaining decrements by 1 per cycle. On the edge where lock_remaining==1: lock_remaining<=0 and go to NORMAL. locked is therefore high for exactly the loaded number of cycles. lockout_num is kept, so escalation continues across lockouts.
- ALARM: sticky; j is ignored; lock_remaining=0. Exits only via admin_clear or rst_n.
- Legacy mode (LOCK_CYCLES=0): never enters LOCKED or ALARM. A wrong entry increments error_count up to MAX_ERRORS and holds there. The next wrong j with error_count==MAX_ERRORS wraps error_count to 0 and still pulses reject. Correct clears to 0 as normal.
- j with X/idle correct when j=0: no effect.
- Reset asserted mid-lockout or in alarm: immediate return to reset values, no pulse.

Test Plan:
1. Defaults, reset, then j wrong x2 -> error_count 1 then 2, reject pulses each time. Then j correct -> error_count=0, pass=1 for one cycle, locked=0.
2. Defaults, 3 wrong j -> on the 3rd edge locked=1, lock_remaining=8, error_count=0. Drive j each cycle during the lock -> no pulses. Remaining counts 7..1, locked=0 after exactly 8 cycles, state NORMAL.
3. Continue with 3 more wrong j -> lock_remaining=16 and locked for 16 cycles. A further 3 wrong j -> alarm=1, locked=0. j correct -> alarm stays 1, no pass. admin_clear -> alarm=0, error_count=0.
4. LOCK_W=4, LOCK_CYCLES=12, second lockout -> lock_remaining saturates to 15.
5. Lockout active with lock_remaining=5, pulse rst_n low mid-cycle -> outputs clear asynchronously before the next edge. Also: admin_clear together with j wrong -> clear wins, reject=0.
6. LOCK_CYCLES=0, MAX_ERRORS=3: wrong x4 -> error_count 1,2,3,0, reject on each, locked and alarm stay 0.
